// File: rtl/weight_stream_pkg.sv
// Shared constants, layer layout and helpers for the streaming weight ROM.
// Layer geometry and the ROM image are computed at elaboration from LAYER_ROWS.
package weight_stream_pkg;

   localparam int unsigned NUM_LAYERS   = 3;
   localparam int unsigned NUM_LANES    = 4;
   localparam int unsigned WEIGHT_WIDTH = 8;
   localparam int unsigned MAX_BURST    = 64;
   localparam int unsigned LAYER_ROWS [NUM_LAYERS] = '{16, 32, 64};
   localparam int unsigned DATA_W       = NUM_LANES * WEIGHT_WIDTH;

   function automatic int unsigned calc_total_rows();
      int unsigned acc;
      acc = 0;
      for (int i = 0; i < NUM_LAYERS; i++) acc += LAYER_ROWS[i];
      return acc;
   endfunction

   function automatic int unsigned calc_max_rows();
      int unsigned mx;
      mx = 0;
      for (int i = 0; i < NUM_LAYERS; i++) if (LAYER_ROWS[i] > mx) mx = LAYER_ROWS[i];
      return mx;
   endfunction

   localparam int unsigned TOTAL_ROWS = calc_total_rows();
   localparam int unsigned MAX_ROWS   = calc_max_rows();
   localparam int unsigned ROW_W      = $clog2(MAX_ROWS);
   localparam int unsigned LAYER_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
   localparam int unsigned LEN_W      = $clog2(MAX_BURST + 1);
   localparam int unsigned ADDR_W     = $clog2(TOTAL_ROWS);
   // Range-check width: wide enough that row + len never wraps.
   localparam int unsigned SUM_W      = ((ROW_W > LEN_W) ? ROW_W : LEN_W) + 1;

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

   typedef logic [NUM_LAYERS-1:0][ADDR_W-1:0] offsets_t;
   typedef logic [TOTAL_ROWS-1:0][DATA_W-1:0] image_t;

   function automatic offsets_t calc_row_offsets();
      offsets_t    offs;
      int unsigned acc;
      offs = '0;
      acc  = 0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         offs[i] = ADDR_W'(acc);
         acc += LAYER_ROWS[i];
      end
      return offs;
   endfunction

   localparam offsets_t LAYER_OFFSET = calc_row_offsets();

   // Weight image, layer-major: lane i of row r holds (r*NUM_LANES + i) mod 2^WEIGHT_WIDTH.
   function automatic image_t init_image();
      image_t img;
      img = '0;
      for (int r = 0; r < TOTAL_ROWS; r++)
         for (int l = 0; l < NUM_LANES; l++)
            img[r][l*WEIGHT_WIDTH +: WEIGHT_WIDTH] = WEIGHT_WIDTH'(r * NUM_LANES + l);
      return img;
   endfunction

endpackage

// File: rtl/weight_row_rom.sv
// Synchronous single-port row ROM; one full beat per read, output holds when idle.
module weight_row_rom
   import weight_stream_pkg::*;
(
   input  logic              clk,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam image_t IMAGE = init_image();

   always_ff @(posedge clk) begin
      if (rd_en) rd_data <= IMAGE[rd_addr];
   end

endmodule

// File: rtl/weight_stream_rom.sv
// Burst-streaming multi-layer weight ROM with valid/ready request and data ports.
// Optional WEIGHT_STREAM_STALL_CNT_EN adds a saturating output-stall counter.
module weight_stream_rom
   import weight_stream_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [LAYER_W-1:0] req_layer,
   input  logic [ROW_W-1:0]   req_row,
   input  logic [LEN_W-1:0]   req_len,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_last,
   output logic               err,
`ifdef WEIGHT_STREAM_STALL_CNT_EN
   output logic [31:0]        stall_cnt,
`endif
   output logic               busy
);

   state_t              state, state_next;
   logic [ADDR_W-1:0]   abs_row;
   logic [LEN_W-1:0]    remaining;
   logic                rd_pending, pend_last;
   logic [DATA_W-1:0]   rd_data;
   logic [DATA_W-1:0]   fifo_data [2];
   logic                fifo_last [2];
   logic                wr_ptr, rd_ptr;
   logic [1:0]          count;

   logic                accept, legal, pop, push, credit, issue;
   logic [SUM_W-1:0]    sel_rows;
   logic [ADDR_W-1:0]   sel_off;

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (count != 2'd0);
   assign out_data  = fifo_data[rd_ptr];
   assign out_last  = fifo_last[rd_ptr] && out_valid;

   assign accept = req_valid && req_ready;
   assign pop    = out_valid && out_ready;
   assign push   = rd_pending;
   // A beat leaving this cycle frees a slot, which keeps the stream bubble-free.
   assign credit = (({1'b0, count} + {2'b0, rd_pending}) < 3'd2) || pop;

   always_comb begin
      sel_rows = '0;
      sel_off  = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if (req_layer == LAYER_W'(i)) begin
            sel_rows = SUM_W'(LAYER_ROWS[i]);
            sel_off  = LAYER_OFFSET[i];
         end
      end
   end

   assign legal = (32'(req_layer) < NUM_LAYERS) && (req_len != '0) &&
                  (32'(req_len) <= MAX_BURST) &&
                  ((SUM_W'(req_row) + SUM_W'(req_len)) <= sel_rows);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      issue      = 1'b0;
      case (state)
         IDLE:   if (accept && legal) state_next = STREAM;
         STREAM: if (credit) begin
            issue = 1'b1;
            if (remaining == LEN_W'(1)) state_next = DRAIN;
         end
         DRAIN:  if (!rd_pending && (count == 2'd0 || (count == 2'd1 && pop)))
            state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Address/length counters, read pipeline tracking and 2-entry output FIFO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         abs_row      <= '0;
         remaining    <= '0;
         rd_pending   <= 1'b0;
         pend_last    <= 1'b0;
         err          <= 1'b0;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         count        <= 2'd0;
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_last[0] <= 1'b0;
         fifo_last[1] <= 1'b0;
      end else begin
         err <= accept && !legal;
         if (accept && legal) begin
            abs_row   <= sel_off + ADDR_W'(req_row);
            remaining <= req_len;
         end else if (issue) begin
            abs_row   <= abs_row + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
         end
         rd_pending <= issue;
         pend_last  <= issue && (remaining == LEN_W'(1));
         if (push) begin
            fifo_data[wr_ptr] <= rd_data;
            fifo_last[wr_ptr] <= pend_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + 2'(push) - 2'(pop);
      end
   end

`ifdef WEIGHT_STREAM_STALL_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                          stall_cnt <= '0;
      else if (accept && legal)                           stall_cnt <= '0;
      else if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
   end
`endif

   weight_row_rom u_rom (
      .clk     (clk),
      .rd_en   (issue),
      .rd_addr (abs_row),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_weight_stream_rom.sv
// Directed self-checking bench for weight_stream_rom.
module tb_weight_stream_rom;
   import weight_stream_pkg::*;

   logic               clk = 1'b0;
   logic               reset;
   logic               req_valid;
   logic               req_ready;
   logic [LAYER_W-1:0] req_layer;
   logic [ROW_W-1:0]   req_row;
   logic [LEN_W-1:0]   req_len;
   logic               out_valid;
   logic               out_ready;
   logic [DATA_W-1:0]  out_data;
   logic               out_last;
   logic               err;
   logic               busy;
`ifdef WEIGHT_STREAM_STALL_CNT_EN
   logic [31:0]        stall_cnt;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   weight_stream_rom dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_layer (req_layer),
      .req_row   (req_row),
      .req_len   (req_len),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .err       (err),
`ifdef WEIGHT_STREAM_STALL_CNT_EN
      .stall_cnt (stall_cnt),
`endif
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] exp_row(input int r);
      logic [31:0] v;
      for (int i = 0; i < 4; i++) v[i*8 +: 8] = 8'((r * 4 + i) % 256);
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input int layer, input int row, input int len);
      req_layer = LAYER_W'(layer);
      req_row   = ROW_W'(row);
      req_len   = LEN_W'(len);
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
   endtask

   // Drain a burst with out_ready high and compare every beat; extra beats show up in the count.
   task automatic collect(input string tag, input int first_row, input int n);
      int got;
      got = 0;
      out_ready = 1'b1;
      for (int c = 0; c < n + 8; c++) begin
         if (out_valid && out_ready) begin
            if (got < n) begin
               check({tag, "_data"}, out_data, exp_row(first_row + got));
               check({tag, "_last"}, 32'(out_last), (got == n - 1) ? 1 : 0);
            end
            got++;
         end
         step();
      end
      check({tag, "_beats"}, got, n);
   endtask

   task automatic run_pattern(output int stalls);
      logic [31:0] held;
      logic        prev_stall;
      int          k;
      bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      stalls     = 0;
      k          = 0;
      prev_stall = 1'b0;
      held       = '0;
      out_ready  = 1'b1;
      send_req(2, 0, 8);
      for (int c = 0; c < 100 && k < 8; c++) begin
         out_ready = pat[c % 4];
         if (prev_stall) check("t2_hold", out_data, held);
         if (out_valid && out_ready) begin
            check("t2_data", out_data, exp_row(48 + k));
            check("t2_last", 32'(out_last), (k == 7) ? 1 : 0);
            k++;
         end
         if (out_valid && !out_ready) stalls++;
         prev_stall = out_valid && !out_ready;
         held       = out_data;
         step();
      end
      check("t2_beats", k, 8);
      check("t2_busy", 32'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int il_layer [4] = '{3, 0, 0, 2};
      int il_row   [4] = '{0, 15, 0, 0};
      int il_len   [4] = '{1, 2, 0, 65};
      int stalls;
      int hs;

      reset     = 1'b1;
      req_valid = 1'b0;
      req_layer = '0;
      req_row   = '0;
      req_len   = '0;
      out_ready = 1'b0;
      step();
      step();
      check("rst_req_ready", 32'(req_ready), 1);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_err", 32'(err), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_out_last", 32'(out_last), 0);
      check("rst_out_data", out_data, 0);
      reset = 1'b0;
      step();

      // 1: layer 1 row 2 len 3 -> abs rows 18..20, first beat two cycles after accept
      out_ready = 1'b1;
      send_req(1, 2, 3);
      check("t1_ready_low", 32'(req_ready), 0);
      check("t1_busy", 32'(busy), 1);
      check("t1_valid_t0", 32'(out_valid), 0);
      step();
      check("t1_valid_t1", 32'(out_valid), 0);
      step();
      check("t1_valid_b0", 32'(out_valid), 1);
      check("t1_data_b0", out_data, 32'h4B4A4948);
      check("t1_last_b0", 32'(out_last), 0);
      step();
      check("t1_valid_b1", 32'(out_valid), 1);
      check("t1_data_b1", out_data, 32'h4F4E4D4C);
      check("t1_last_b1", 32'(out_last), 0);
      step();
      check("t1_valid_b2", 32'(out_valid), 1);
      check("t1_data_b2", out_data, 32'h53525150);
      check("t1_last_b2", 32'(out_last), 1);
      step();
      check("t1_valid_end", 32'(out_valid), 0);
      check("t1_busy_end", 32'(busy), 0);
      check("t1_ready_end", 32'(req_ready), 1);

      // 2: backpressure burst, layer 2 rows 48..55
      run_pattern(stalls);
      step();

      // 3: illegal requests
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send_req(il_layer[i], il_row[i], il_len[i]);
         check("t3_err", 32'(err), 1);
         check("t3_ready", 32'(req_ready), 1);
         check("t3_valid", 32'(out_valid), 0);
         step();
         check("t3_err_clr", 32'(err), 0);
         check("t3_valid2", 32'(out_valid), 0);
      end

      // 4: last row of last layer
      send_req(2, 63, 1);
      check("t4_err", 32'(err), 0);
      check("t4_busy", 32'(busy), 1);
      step();
      step();
      check("t4_data", out_data, 32'hBFBEBDBC);
      collect("t4", 111, 1);

      // 5: reset while the 3rd of 6 beats is stalled
      out_ready = 1'b1;
      send_req(0, 0, 6);
      hs = 0;
      for (int c = 0; c < 20 && hs < 2; c++) begin
         if (out_valid && out_ready) hs++;
         step();
      end
      check("t5_hs", hs, 2);
      out_ready = 1'b0;
      step();
      check("t5_stall_valid", 32'(out_valid), 1);
      check("t5_stall_data", out_data, exp_row(2));
      reset = 1'b1;
      #1;
      check("t5_async_valid", 32'(out_valid), 0);
      check("t5_async_busy", 32'(busy), 0);
      step();
      step();
      reset = 1'b0;
      check("t5_ready_after", 32'(req_ready), 1);
      out_ready = 1'b1;
      step();
      step();
      check("t5_no_stale", 32'(out_valid), 0);
      send_req(0, 0, 1);
      collect("t5", 0, 1);

`ifdef WEIGHT_STREAM_STALL_CNT_EN
      // 6: stall counter over a fixed stall pattern, cleared on the next legal accept
      run_pattern(stalls);
      check("t6_stall_cnt", stall_cnt, stalls);
      step();
      out_ready = 1'b1;
      send_req(0, 0, 1);
      check("t6_cleared", stall_cnt, 0);
      collect("t6", 0, 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
